mem_port_arbiter: RTL and testbench

- Shares the single external instruction/data memory read port between two block-refill requesters: port 0 is the icache refill and port 1 is the dcache refill.
- Each requester holds a level request with a block-aligned address. It expects BLOCK_SIZE data beats, each qualified by a valid strobe.
- The arbiter grants one owner at a time and forwards beats only to that owner. It counts beats, releases the port after the last beat, and alternates priority on contention.
- It sits between the cache refill ports and the memory model / bus bridge.

---
 rtl/mem_pkg.sv | 11 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the refill-port arbiter: FSM states, grant vector and
// default burst geometry.
package mem_pkg;
    localparam int BLOCK_SIZE = 8;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} arb_state_t;

    // One-hot owner: bit 0 = icache refill, bit 1 = dcache refill.
    typedef logic [1:0] grant_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright; on contention the
// port that did not own the bus last time wins.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output grant_t     win
);
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_owner ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory read port between icache and dcache refill bursts;
// grants one owner per burst, counts beats and alternates on contention.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int BLOCK_SIZE = mem_pkg::BLOCK_SIZE,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = mem_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_val,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_val,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_val,
    output logic [1:0]        grant,
    output logic              busy
);
    localparam int CNT_W = $clog2(BLOCK_SIZE);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_owner_q, last_owner_d;
    grant_t            win;
    logic              beat;
    logic              owner_req;

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_q),
        .win        (win)
    );

    // Beats outside BURST are stray and never reach a requester.
    assign beat      = (state_q == BURST) && bus_val;
    assign owner_req = grant_q[1] ? m1_req : m0_req;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        bus_addr_d   = bus_addr_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d    = win;
                    bus_addr_d = win[1] ? m1_addr : m0_addr;
                    cnt_d      = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // Owner dropping req does not abort: memory cannot stop a burst.
                if (bus_val) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
                        last_owner_d = grant_q[1];
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!owner_req) begin
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            bus_addr_q   <= '0;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            bus_addr_q   <= bus_addr_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign m0_val   = beat && grant_q[0];
    assign m1_val   = beat && grant_q[1];
    assign m0_data  = m0_val ? bus_data : '0;
    assign m1_data  = m1_val ? bus_data : '0;
    assign bus_req  = (state_q == BURST);
    assign bus_addr = bus_addr_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: stimulus queues expected beats and burst starts, a
// negedge monitor pops and compares whatever the arbiter presents.
module tb_mem_port_arbiter;
    typedef struct {
        logic [1:0]  own;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_data, m1_data;
    logic        m0_val, m1_val;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_data = '0;
    logic        bus_val = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t beat_q[$];
    exp_t addr_q[$];

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_data  (m0_data),
        .m0_val   (m0_val),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_data  (m1_data),
        .m1_val   (m1_val),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_val  (bus_val),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic expect_burst(input logic [1:0] own, input logic [31:0] addr);
        addr_q.push_back('{own: own, val: addr});
    endtask

    // Memory model: waits (bounded) for bus_req, then returns nbeats beats,
    // each preceded by gap idle cycles; beat i carries base + (i+1)*0x11.
    task automatic burst(input logic [1:0] own, input int nbeats, input int gap,
                         input logic [31:0] base);
        int waited = 0;
        while (!bus_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bus_req_timeout", bus_req, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                bus_val = 1'b0;
            end
            step();
            bus_val  = 1'b1;
            bus_data = base + 32'((i + 1) * 32'h11);
            beat_q.push_back('{own: own, val: bus_data});
        end
        step();
        bus_val = 1'b0;
    endtask

    // Monitor: every forwarded beat and every burst start is matched in order.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (m0_val || m1_val) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", {m1_val, m0_val}, 2'b00);
                    end else begin
                        e = beat_q.pop_front();
                        check("beat_owner_data", {30'd0, m1_val, m0_val, m1_data | m0_data},
                              {30'd0, e.own, e.val});
                        check("nonowner_data", m0_val ? m1_data : m0_data, 32'd0);
                    end
                end
                if (bus_req && !prev_req) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_burst", bus_req, 1'b0);
                    end else begin
                        e = addr_q.pop_front();
                        check("burst_grant_addr", {30'd0, grant, bus_addr}, {30'd0, e.own, e.val});
                    end
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_vals", {m1_val, m0_val}, 2'b00);
        do_reset();

        // Single port 0 burst
        m0_addr = 32'h0000_1A20;
        expect_burst(2'b01, 32'h0000_1A20);
        m0_req = 1'b1;
        burst(2'b01, 8, 0, 32'h0);
        @(negedge clk);
        check("t1_drain_bus_req", bus_req, 1'b0);
        check("t1_drain_grant", grant, 2'b01);
        check("t1_drain_busy", busy, 1'b1);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("t1_grant_held", grant, 2'b01);
        @(negedge clk);
        check("t1_idle_grant", grant, 2'b00);
        check("t1_idle_busy", busy, 1'b0);

        // Stray beat in IDLE
        step();
        bus_val = 1'b1;
        bus_data = 32'hDEAD_0001;
        @(negedge clk);
        check("stray_idle_vals", {m1_val, m0_val}, 2'b00);
        step();
        bus_val = 1'b0;

        // Contention from reset: port 0 first, port 1 straight after
        do_reset();
        m0_addr = 32'h0000_2000;
        m1_addr = 32'h0000_3040;
        expect_burst(2'b01, 32'h0000_2000);
        expect_burst(2'b10, 32'h0000_3040);
        m0_req = 1'b1;
        m1_req = 1'b1;
        burst(2'b01, 8, 0, 32'h100);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("t2_still_drain", busy, 1'b1);
        @(negedge clk);
        check("t2_idle_gap", busy, 1'b0);
        @(negedge clk);
        check("t2_p1_bus_req", bus_req, 1'b1);
        check("t2_p1_grant", grant, 2'b10);
        burst(2'b10, 8, 0, 32'h200);
        step();
        m1_req = 1'b0;
        step();
        step();

        // Alternation over four bursts
        do_reset();
        m0_addr = 32'h0000_4000;
        m1_addr = 32'h0000_5000;
        for (int k = 0; k < 4; k++)
            expect_burst((k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 32'h4000 : 32'h5000);
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            burst((k % 2 == 0) ? 2'b01 : 2'b10, 8, 0, 32'((k + 1) << 12));
            if (k % 2 == 0) m0_req = 1'b0;
            else            m1_req = 1'b0;
            step();
            if (k < 3) begin
                if (k % 2 == 0) m0_req = 1'b1;
                else            m1_req = 1'b1;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        step();
        check("t3_idle", busy, 1'b0);

        // Gapped beats every third cycle, then a stray beat in DRAIN
        m0_addr = 32'h0000_6000;
        expect_burst(2'b01, 32'h0000_6000);
        m0_req = 1'b1;
        burst(2'b01, 8, 2, 32'h300);
        @(negedge clk);
        check("t4_end_bus_req", bus_req, 1'b0);
        step();
        bus_val = 1'b1;
        bus_data = 32'hBEEF_0002;
        @(negedge clk);
        check("stray_drain_vals", {m1_val, m0_val}, 2'b00);
        check("stray_drain_busy", busy, 1'b1);
        step();
        bus_val = 1'b0;
        m0_req = 1'b0;
        step();
        step();

        // Reset mid-burst after beat 3
        m0_addr = 32'h0000_7000;
        expect_burst(2'b01, 32'h0000_7000);
        m0_req = 1'b1;
        burst(2'b01, 3, 0, 32'h400);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_async_grant", grant, 2'b00);
        check("t5_async_bus_req", bus_req, 1'b0);
        check("t5_async_busy", busy, 1'b0);
        m0_req = 1'b0;
        step();
        reset = 1'b0;
        m1_addr = 32'h0000_7100;
        expect_burst(2'b10, 32'h0000_7100);
        m1_req = 1'b1;
        burst(2'b10, 8, 0, 32'h500);
        step();
        m1_req = 1'b0;
        step();
        step();

        // Owner drops req after beat 5; beats 6-8 still delivered
        m1_addr = 32'h0000_8000;
        expect_burst(2'b10, 32'h0000_8000);
        m1_req = 1'b1;
        burst(2'b10, 5, 0, 32'h600);
        m1_req = 1'b0;
        burst(2'b10, 3, 0, 32'h600 + 32'h55);
        @(negedge clk);
        check("t6_drain_busy", busy, 1'b1);
        check("t6_drain_grant", grant, 2'b10);
        check("t6_drain_bus_req", bus_req, 1'b0);
        @(negedge clk);
        check("t6_idle_busy", busy, 1'b0);
        check("t6_idle_grant", grant, 2'b00);

        step();
        check("beat_q_empty", beat_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
